// File: rtl/log_mul_pkg.sv
// Shared definitions for the fp16 log-domain multiplier and its LUT loader.
//   FLOAT_LEN / EXP_LEN / MANT_LEN : fp16 field widths
//   LUT_SIZE                       : entries in each log2 / exp2 LUT
//   loader_state_t                 : loader FSM states
//   FP16_QNAN / FP16_POS_INF       : fp16 special encodings
package log_mul_pkg;

    localparam int unsigned FLOAT_LEN = 16;
    localparam int unsigned EXP_LEN   = 5;
    localparam int unsigned MANT_LEN  = 10;
    localparam int unsigned LUT_SIZE  = 128;

    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [15:0] FP16_POS_INF = 16'h7C00;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        RUN
    } loader_state_t;

endpackage

// File: rtl/log_mul_valid_pipe.sv
// Valid-bit shift register of configurable depth.
//   clk, rst  : clock, synchronous active-high reset (clears all stages)
//   valid_in  : valid entering stage 0
//   valid_out : valid leaving the last stage (DEPTH cycles later)
module log_mul_valid_pipe #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    output logic valid_out
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= valid_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign valid_out = stages[DEPTH-1];

endmodule

// File: rtl/log_mul_lut_loader.sv
// LUT loader and operand gate in front of the fp16 log-domain multiplier.
// Streams exactly LUT_SIZE host beats into the multiplier's LUT write port,
// waits until the multiplier's write-done flag is certainly visible, then
// opens the operand path and tags results with a latency-matched valid.
//   clk, rst                     : clock, synchronous active-high reset
//   cfg_valid/cfg_ready          : host LUT beat handshake
//   cfg_log2_data/cfg_exp2_data  : LUT entry carried by a beat
//   lut_wr_en, log2_lut_data_in,
//   exp2_lut_data_in             : multiplier LUT write port
//   lut_loaded                   : LUTs loaded, operand path open
//   in_valid/in_ready, in_a/in_b : operand pair handshake
//   mul_a/mul_b, mul_result      : multiplier operand and result ports
//   out_valid/out_result         : tagged result (0 when not valid)
module log_mul_lut_loader #(
    parameter int unsigned FLOAT_LEN     = log_mul_pkg::FLOAT_LEN,
    parameter int unsigned MANT_LEN      = log_mul_pkg::MANT_LEN,
    parameter int unsigned LUT_SIZE      = log_mul_pkg::LUT_SIZE,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned MUL_LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [MANT_LEN-1:0]  cfg_log2_data,
    input  logic [FLOAT_LEN-1:0] cfg_exp2_data,
    output logic                 lut_wr_en,
    output logic [MANT_LEN-1:0]  log2_lut_data_in,
    output logic [FLOAT_LEN-1:0] exp2_lut_data_in,
    output logic                 lut_loaded,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLOAT_LEN-1:0] in_a,
    input  logic [FLOAT_LEN-1:0] in_b,
    output logic [FLOAT_LEN-1:0] mul_a,
    output logic [FLOAT_LEN-1:0] mul_b,
    input  logic [FLOAT_LEN-1:0] mul_result,
    output logic                 out_valid,
    output logic [FLOAT_LEN-1:0] out_result
);

    import log_mul_pkg::*;

    localparam int unsigned CNT_W = $clog2(LUT_SIZE) + 1;
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(LUT_SIZE - 1);
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(1);

    loader_state_t    state;
    logic [CNT_W-1:0] beat_cnt;
    logic [SET_W-1:0] settle_cnt;

    logic cfg_fire;
    logic in_fire;

    assign cfg_fire = cfg_valid & cfg_ready;
    assign in_fire  = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= LOAD;
            beat_cnt         <= '0;
            settle_cnt       <= '0;
            cfg_ready        <= 1'b0;
            lut_wr_en        <= 1'b0;
            log2_lut_data_in <= '0;
            exp2_lut_data_in <= '0;
            lut_loaded       <= 1'b0;
            in_ready         <= 1'b0;
            mul_a            <= '0;
            mul_b            <= '0;
        end else begin
            lut_wr_en <= 1'b0;
            // Idle operand slots present zero to the multiplier.
            mul_a     <= in_fire ? in_a : '0;
            mul_b     <= in_fire ? in_b : '0;

            case (state)
                LOAD: begin
                    cfg_ready <= 1'b1;
                    if (cfg_fire) begin
                        lut_wr_en        <= 1'b1;
                        log2_lut_data_in <= cfg_log2_data;
                        exp2_lut_data_in <= cfg_exp2_data;
                        beat_cnt         <= beat_cnt + 1'b1;
                        // Drop ready in the same edge as the final beat so a
                        // back-to-back host can never land beat LUT_SIZE+1.
                        if (beat_cnt == LAST_BEAT) begin
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_INIT;
                            cfg_ready  <= 1'b0;
                        end
                    end
                end

                SETTLE: begin
                    cfg_ready <= 1'b0;
                    // Leave once SETTLE_CYCLES cycles have elapsed since the
                    // final strobe was presented.
                    if (settle_cnt <= SETTLE_LAST) begin
                        state      <= RUN;
                        lut_loaded <= 1'b1;
                        in_ready   <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                RUN: begin
                    cfg_ready  <= 1'b0;
                    lut_loaded <= 1'b1;
                    in_ready   <= 1'b1;
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    // One stage for the operand register, MUL_LATENCY for the multiplier.
    log_mul_valid_pipe #(
        .DEPTH(1 + MUL_LATENCY)
    ) u_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .valid_in (in_fire),
        .valid_out(out_valid)
    );

    assign out_result = out_valid ? mul_result : '0;

endmodule

// File: tb/tb_log_mul_lut_loader.sv
module tb_log_mul_lut_loader;

    import log_mul_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_ready;
    logic [MANT_LEN-1:0]  cfg_log2_data = '0;
    logic [FLOAT_LEN-1:0] cfg_exp2_data = '0;
    logic                 lut_wr_en;
    logic [MANT_LEN-1:0]  log2_lut_data_in;
    logic [FLOAT_LEN-1:0] exp2_lut_data_in;
    logic                 lut_loaded;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [FLOAT_LEN-1:0] in_a = '0;
    logic [FLOAT_LEN-1:0] in_b = '0;
    logic [FLOAT_LEN-1:0] mul_a;
    logic [FLOAT_LEN-1:0] mul_b;
    logic [FLOAT_LEN-1:0] mul_result;
    logic                 out_valid;
    logic [FLOAT_LEN-1:0] out_result;

    always #5 clk = ~clk;

    log_mul_lut_loader #(
        .FLOAT_LEN    (FLOAT_LEN),
        .MANT_LEN     (MANT_LEN),
        .LUT_SIZE     (LUT_SIZE),
        .SETTLE_CYCLES(2),
        .MUL_LATENCY  (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_log2_data   (cfg_log2_data),
        .cfg_exp2_data   (cfg_exp2_data),
        .lut_wr_en       (lut_wr_en),
        .log2_lut_data_in(log2_lut_data_in),
        .exp2_lut_data_in(exp2_lut_data_in),
        .lut_loaded      (lut_loaded),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_a            (in_a),
        .in_b            (in_b),
        .mul_a           (mul_a),
        .mul_b           (mul_b),
        .mul_result      (mul_result),
        .out_valid       (out_valid),
        .out_result      (out_result)
    );

    // Operand vectors with hand-computed fp16 products.
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
    } vec_t;

    vec_t tbl [10];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_fire = -1;
    int last_fire = -1;

    // Multiplier model: 2 register stages, product looked up from the table.
    logic [15:0] m1, m2;

    function automatic logic [15:0] mock_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        r = 16'hBEEF;
        for (int i = 0; i < 10; i++)
            if (tbl[i].a == a && tbl[i].b == b) r = tbl[i].prod;
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m1 <= '0;
            m2 <= '0;
        end else begin
            m1 <= mock_mul(mul_a, mul_b);
            m2 <= m1;
        end
    end
    assign mul_result = m2;

    // Multiplier LUT write-port model plus continuous protocol monitor.
    logic [MANT_LEN-1:0]  log_mem [LUT_SIZE];
    logic [FLOAT_LEN-1:0] exp_mem [LUT_SIZE];
    int wr_cnt = 0;
    int first_wr = -1;
    int last_wr = -1;
    int pulse_err = 0;
    int gate_err = 0;
    bit prev_fire = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            wr_cnt    = 0;
            prev_fire = 1'b0;
        end else begin
            if (lut_wr_en !== prev_fire) pulse_err++;
            if (lut_wr_en) begin
                if (wr_cnt == 0) first_wr = cyc;
                last_wr = cyc;
                if (wr_cnt < LUT_SIZE) begin
                    log_mem[wr_cnt] = log2_lut_data_in;
                    exp_mem[wr_cnt] = exp2_lut_data_in;
                end
                wr_cnt++;
            end
            prev_fire = cfg_valid & cfg_ready;
            if (!lut_loaded && (in_ready || mul_a != 0 || mul_b != 0 || out_valid)) gate_err++;
            if (lut_loaded && cfg_ready) gate_err++;
            if (!out_valid && out_result != 0) gate_err++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [MANT_LEN-1:0] exp_log2(input int variant, input int i);
        return (variant == 0) ? MANT_LEN'(i) : MANT_LEN'(127 - i);
    endfunction

    function automatic logic [FLOAT_LEN-1:0] exp_exp2(input int variant, input int i);
        return (variant == 0) ? 16'h3C00 + 16'(i) : 16'h4000 + 16'(3 * i);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_cfg_ready"},  32'(cfg_ready), 0);
        check({tag, "_lut_wr_en"},  32'(lut_wr_en), 0);
        check({tag, "_log2_data"},  32'(log2_lut_data_in), 0);
        check({tag, "_exp2_data"},  32'(exp2_lut_data_in), 0);
        check({tag, "_lut_loaded"}, 32'(lut_loaded), 0);
        check({tag, "_in_ready"},   32'(in_ready), 0);
        check({tag, "_mul_ab"},     {mul_a, mul_b}, 0);
        check({tag, "_out_valid"},  32'(out_valid), 0);
        check({tag, "_out_result"}, 32'(out_result), 0);
    endtask

    // Offers n beats; returns in the cycle after the last fire, cfg_valid still high.
    task automatic load(input int n, input bit gaps, input int variant);
        bit fired;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                cfg_valid = 1'b0;
                repeat (g) step();
            end
            cfg_valid     = 1'b1;
            cfg_log2_data = exp_log2(variant, i);
            cfg_exp2_data = exp_exp2(variant, i);
            fired = 1'b0;
            for (int k = 0; k < 16 && !fired; k++) begin
                if (cfg_ready) begin
                    fired = 1'b1;
                    if (i == 0) first_fire = cyc;
                    last_fire = cyc;
                end
                step();
            end
            if (!fired) check($sformatf("beat_accept_%0d", i), 32'(fired), 1);
        end
        cfg_log2_data = '1;
        cfg_exp2_data = '1;
    endtask

    task automatic check_lut(input string tag, input int variant);
        int bad = 0;
        for (int i = 0; i < LUT_SIZE; i++)
            if (log_mem[i] !== exp_log2(variant, i) || exp_mem[i] !== exp_exp2(variant, i)) bad++;
        check({tag, "_strobe_count"}, 32'(wr_cnt), LUT_SIZE);
        check({tag, "_lut_data_bad_entries"}, 32'(bad), 0);
    endtask

    // Streams tbl[0..n-1] back to back and checks operands, valid and results.
    task automatic stream(input string tag, input int n);
        logic exp_v;
        logic [15:0] exp_r;
        logic [31:0] exp_ab;
        for (int j = 0; j < n + 4; j++) begin
            exp_v  = (j >= 3 && j < n + 3);
            exp_r  = exp_v ? tbl[j-3].prod : 16'h0000;
            exp_ab = (j >= 1 && j <= n) ? {tbl[j-1].a, tbl[j-1].b} : 32'h0;
            check($sformatf("%s_mul_ab_%0d", tag, j), {mul_a, mul_b}, exp_ab);
            check($sformatf("%s_out_valid_%0d", tag, j), 32'(out_valid), 32'(exp_v));
            check($sformatf("%s_out_result_%0d", tag, j), 32'(out_result), 32'(exp_r));
            if (exp_v && j - 3 == 5)
                check($sformatf("%s_nan_slot", tag),
                      32'((out_result[FLOAT_LEN-2 -: EXP_LEN] == 5'h1F) && (out_result[MANT_LEN-1:0] != 0)), 1);
            if (j < n) begin
                in_valid = 1'b1;
                in_a     = tbl[j].a;
                in_b     = tbl[j].b;
            end else begin
                in_valid = 1'b0;
                in_a     = '0;
                in_b     = '0;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h4000, 16'h4200, 16'h4600};   // 2 * 3 = 6
        tbl[1] = '{16'h3C00, 16'h3C00, 16'h3C00};   // 1 * 1 = 1
        tbl[2] = '{16'h3800, 16'h4400, 16'h3C00};   // 0.5 * 4 = 1
        tbl[3] = '{16'hC000, 16'h4200, 16'hC600};   // -2 * 3 = -6
        tbl[4] = '{16'h3E00, 16'h3E00, 16'h4080};   // 1.5 * 1.5 = 2.25
        tbl[5] = '{16'h0000, FP16_POS_INF, FP16_QNAN}; // 0 * Inf = NaN
        tbl[6] = '{16'h4000, 16'h4000, 16'h4400};   // 2 * 2 = 4
        tbl[7] = '{16'hBC00, 16'hBC00, 16'h3C00};   // -1 * -1 = 1
        tbl[8] = '{16'h3D00, 16'h4000, 16'h4100};   // 1.25 * 2 = 2.5
        tbl[9] = '{16'h4200, 16'h4200, 16'h4880};   // 3 * 3 = 9

        // Reset state
        rst = 1'b1;
        repeat (2) step();
        check_zero("reset");

        // Back-to-back load with operands pushed during LOAD/SETTLE
        rst      = 1'b0;
        in_valid = 1'b1;
        in_a     = 16'h4000;
        in_b     = 16'h4200;
        load(LUT_SIZE, 1'b0, 0);
        // cycle t+1 (t = last fire); cfg_valid stays high as a 129th beat
        check("t1_lut_wr_en", 32'(lut_wr_en), 1);
        check("t1_cfg_ready", 32'(cfg_ready), 0);
        check("t1_lut_loaded", 32'(lut_loaded), 0);
        check("t1_in_ready", 32'(in_ready), 0);
        step();
        check("t2_lut_wr_en", 32'(lut_wr_en), 0);
        check("t2_lut_loaded", 32'(lut_loaded), 0);
        check("t2_in_ready", 32'(in_ready), 0);
        check("t2_mul_a", 32'(mul_a), 0);
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        step();
        check("t3_lut_loaded", 32'(lut_loaded), 1);
        check("t3_in_ready", 32'(in_ready), 1);
        check("t3_cfg_ready", 32'(cfg_ready), 0);
        repeat (4) step();
        cfg_valid = 1'b0;
        check("b2b_first_strobe_cycle", 32'(first_wr), 32'(first_fire + 1));
        check("b2b_last_strobe_cycle", 32'(last_wr), 32'(last_fire + 1));
        check_lut("b2b", 0);

        stream("single", 1);
        stream("burst", 10);

        // Reset in the middle of a load, then reload with random gaps
        rst = 1'b1;
        step();
        rst = 1'b0;
        load(50, 1'b0, 0);
        rst = 1'b1;
        step();
        check_zero("midreset");
        rst       = 1'b0;
        cfg_valid = 1'b0;
        load(LUT_SIZE, 1'b1, 1);
        cfg_valid = 1'b0;
        check("gap_cfg_ready_after_last", 32'(cfg_ready), 0);
        for (int k = 0; k < 10 && !lut_loaded; k++) step();
        check("reload_lut_loaded", 32'(lut_loaded), 1);
        check_lut("reload", 1);
        stream("reload_burst", 10);

        check("strobe_follows_fire_errors", 32'(pulse_err), 0);
        check("gating_errors", 32'(gate_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
